// File: rtl/apb_master_if.sv
// apb_master_if: command/response and APB3 signals between the requester, apb_master and the register file.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              I_CMD_VALID;
    logic              I_CMD_WRITE;
    logic [ADDR_W-1:0] I_CMD_ADDR;
    logic [DATA_W-1:0] I_CMD_WDATA;
    logic              O_CMD_READY;
    logic              O_RSP_VALID;
    logic [DATA_W-1:0] O_RSP_RDATA;
    logic              O_RSP_ERR;
    logic              O_PSEL;
    logic              O_PENABLE;
    logic              O_PWRITE;
    logic [ADDR_W-1:0] O_PADDR;
    logic [DATA_W-1:0] O_PWDATA;
    logic [DATA_W-1:0] I_PRDATA;
    logic              I_PREADY;
    logic              I_PSLVERR;
    modport master (
        input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA, I_PRDATA, I_PREADY, I_PSLVERR,
        output O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
        output O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
    );
    modport slave (
        output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA, I_PRDATA, I_PREADY, I_PSLVERR,
        input  O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
        input  O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: turns single-beat commands into APB3 transfers, with a wait-state timeout
// so a hung target cannot stall the requester.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic          I_PCLK,
    input logic          I_PRESET_N,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              timeout_hit;
    // The count is compared after this cycle's increment, so the Nth low-ready cycle aborts.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT));
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: if (bus.I_CMD_VALID) begin
                state_d  = SETUP;
                pwrite_d = bus.I_CMD_WRITE;
                paddr_d  = bus.I_CMD_ADDR;
                pwdata_d = bus.I_CMD_WDATA;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: if (bus.I_PREADY) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = bus.I_PSLVERR;
                rsp_rdata_d = pwrite_q ? '0 : bus.I_PRDATA;
            end else begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
                if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
    assign bus.O_CMD_READY = state_q == IDLE;
    assign bus.O_PSEL      = state_q != IDLE;
    assign bus.O_PENABLE   = state_q == ACCESS;
    assign bus.O_PWRITE    = pwrite_q;
    assign bus.O_PADDR     = paddr_q;
    assign bus.O_PWDATA    = pwdata_q;
    assign bus.O_RSP_VALID = rsp_valid_q;
    assign bus.O_RSP_ERR   = rsp_err_q;
    assign bus.O_RSP_RDATA = rsp_rdata_q;
endmodule

// File: doc/apb_master.md
# apb_master

APB initiator for the rotate accelerator's configuration path. It turns single-beat commands from a local requester (test host or control sequencer) into APB3 transfers toward the register file, and returns read data and error status. It is the initiating end of the same APB link that the register file answers. It also adds a bounded wait-state timeout so a missing or hung target cannot stall the requester.

## Interface
- ADDR_W, 32, width of command address and O_PADDR
- DATA_W, 32, width of write/read data
- TIMEOUT, 16, maximum ACCESS cycles with I_PREADY low before abort; 0 disables timeout; legal range 0..65535
- I_PCLK  in  1  single clock, all logic on rising edge
- I_PRESET_N  in  1  reset, asynchronous assert, active-low
- I_CMD_VALID  in  1  requester has a command
- I_CMD_WRITE  in  1  1 = write, 0 = read
- I_CMD_ADDR  in  ADDR_W  target address
- I_CMD_WDATA  in  DATA_W  write data (ignored for reads)
- O_CMD_READY  out  1  command accepted when high with I_CMD_VALID
- O_RSP_VALID  out  1  one-cycle pulse, transfer finished
- O_RSP_RDATA  out  DATA_W  read data; 0 for writes and on timeout
- O_RSP_ERR  out  1  I_PSLVERR captured, or timeout
- O_PSEL, O_PENABLE, O_PWRITE  out  1 each  APB control
- O_PADDR  out  ADDR_W  APB address
- O_PWDATA  out  DATA_W  APB write data
- I_PRDATA  in  DATA_W  APB read data
- I_PREADY  in  1  APB ready
- I_PSLVERR  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS (2-bit encoded).
- IDLE:
  - O_CMD_READY=1, O_PSEL=0, O_PENABLE=0.
  - On I_CMD_VALID=1, latch WRITE/ADDR/WDATA into O_PWRITE/O_PADDR/O_PWDATA and go to SETUP.
- SETUP:
  - O_PSEL=1, O_PENABLE=0, O_CMD_READY=0.
  - Always go to ACCESS next cycle.
  - Clear the wait counter.
- ACCESS:
  - O_PSEL=1, O_PENABLE=1.
  - If I_PREADY=1:
    - Register O_RSP_VALID=1 and O_RSP_ERR=I_PSLVERR.
    - Register O_RSP_RDATA=I_PRDATA for reads, 0 for writes.
    - Go to IDLE.
  - Else, increment the wait counter (16-bit, saturating). If TIMEOUT!=0 and the counter reaches TIMEOUT:
    - Register O_RSP_VALID=1, O_RSP_ERR=1, O_RSP_RDATA=0.
    - Go to IDLE. O_PSEL and O_PENABLE drop with the state change.
- O_PADDR, O_PWRITE and O_PWDATA are stable from SETUP through the last ACCESS cycle. In IDLE they hold their last values.
- Command fields are sampled only at acceptance. Changes on I_CMD_* afterwards have no effect.
- I_PREADY and I_PSLVERR are ignored outside ACCESS.
- O_RSP_RDATA and O_RSP_ERR hold their values until the next response.

## Timing
- Reset values:
  - All outputs 0 except O_CMD_READY=1 (IDLE).
  - Wait counter 0.
- Assertion of I_PRESET_N low clears immediately, mid-transfer included. The aborted transfer produces no response.
- Command accepted at edge E0 (I_CMD_VALID & O_CMD_READY):
  - SETUP in cycle after E0.
  - ACCESS in the cycle after that.
  - With zero wait states, O_RSP_VALID is high in the 3rd cycle after E0, and O_CMD_READY is high in that same cycle.
- Each wait state adds one cycle.
- Minimum command spacing is 3 cycles. A command presented in the O_RSP_VALID cycle is accepted at that cycle's edge.
- Timeout with TIMEOUT=N: abort after exactly N ACCESS cycles with I_PREADY low. O_RSP_VALID is high in the cycle after the Nth low-ready ACCESS cycle.
- I_PREADY=1 on the same edge the counter would reach TIMEOUT: the normal completion wins, with O_RSP_ERR=I_PSLVERR.

## Test plan
- Write 0x0000_0004 ← 0xDEAD_BEEF, target I_PREADY=1 immediately:
  - SETUP then one ACCESS cycle.
  - O_PADDR=0x4 and O_PWDATA=0xDEADBEEF stable across both.
  - O_RSP_VALID 3 cycles after acceptance, ERR=0, RDATA=0.
- Read 0x8 with I_PREADY low for 2 ACCESS cycles and I_PRDATA=0x1234_5678 on the ready cycle:
  - ACCESS lasts 3 cycles.
  - O_RSP_RDATA=0x12345678, ERR=0, valid 5 cycles after acceptance.
- Read with I_PSLVERR=1 on the ready cycle → O_RSP_ERR=1 with O_RSP_RDATA=I_PRDATA.
- TIMEOUT=4 with I_PREADY held low:
  - Exactly 4 ACCESS cycles, then O_PSEL=0.
  - O_RSP_VALID=1, ERR=1, RDATA=0.
  - Back in IDLE with O_CMD_READY=1.
- Back-to-back write then read, with I_CMD_VALID held high → second SETUP starts in the cycle after the first O_RSP_VALID, and no APB cycle shows O_PENABLE=1 with O_PSEL=0.
- I_PRESET_N pulsed low mid-ACCESS:
  - Outputs go to reset values asynchronously, with no O_RSP_VALID.
  - After release, a new write completes normally.
